// File: rtl/io_block_cfg.sv
// io_block_cfg
//   Fabric-edge I/O block. It connects the external input pins onto the
//   single, double and global routing tracks, and samples those tracks onto
//   the external output pins. The configuration lives in an internal serial
//   shift chain. Each pin can run combinationally or through a register.
//   A sticky flag reports when two or more input pins drive the same track.
//
// Ports
//   clk, rst               : clock (rising edge), synchronous active-high reset
//   cfg_en, cfg_in         : config chain shift enable and serial data in
//   cfg_out                : config chain serial out (cfg[0])
//   single/double/global_in: resolved track values seen by this block
//   single/double/global_out, _oe : track drive values and drive enables
//   external_input         : pad inputs
//   external_output        : pad outputs
//   conflict               : sticky multi-driver contention flag
//
// Config layout: pin p owns cfg[p*WF +: WF]. Input pins come first
// (p = 0..EXTIN-1), then output pins (p = EXTIN+o). Field bits [WT-1:0]
// are track selects ordered singles, doubles, globals. Bit WT selects
// registered mode.
module io_block_cfg #(
  parameter int WS     = 7,
  parameter int WD     = 6,
  parameter int WG     = 3,
  parameter int EXTIN  = 5,
  parameter int EXTOUT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic              cfg_in,
  output logic              cfg_out,
  input  logic [WS-1:0]     single_in,
  input  logic [WD-1:0]     double_in,
  input  logic [WG-1:0]     global_in,
  output logic [WS-1:0]     single_out,
  output logic [WD-1:0]     double_out,
  output logic [WG-1:0]     global_out,
  output logic [WS-1:0]     single_oe,
  output logic [WD-1:0]     double_oe,
  output logic [WG-1:0]     global_oe,
  input  logic [EXTIN-1:0]  external_input,
  output logic [EXTOUT-1:0] external_output,
  output logic              conflict
);

  localparam int WT = WS + WD + WG;
  localparam int WF = WT + 1;
  localparam int CW = (EXTIN + EXTOUT) * WF;

  logic [CW-1:0]     cfg;
  logic [EXTIN-1:0]  in_q;
  logic [EXTOUT-1:0] out_q;

  logic [WT-1:0]     track_in;
  logic [WT-1:0]     sel;
  logic [WT-1:0]     seen;
  logic [WT-1:0]     dup;
  logic [WT-1:0]     drv;
  logic [WT-1:0]     oe_all;
  logic [WT-1:0]     out_all;
  logic [EXTIN-1:0]  in_val;
  logic [EXTOUT-1:0] out_comb;
  logic              contention;

  assign track_in = {global_in, double_in, single_in};

  always_comb begin
    sel             = '0;
    seen            = '0;
    dup             = '0;
    drv             = '0;
    in_val          = '0;
    out_comb        = '0;
    external_output = '0;

    // A track already claimed by an earlier pin and selected again is a
    // multi-driver conflict.
    for (int i = 0; i < EXTIN; i++) begin
      sel       = cfg[i*WF +: WT];
      in_val[i] = cfg[i*WF + WT] ? in_q[i] : external_input[i];
      dup       = dup | (seen & sel);
      seen      = seen | sel;
      if (in_val[i]) drv = drv | sel;
    end

    for (int o = 0; o < EXTOUT; o++) begin
      sel         = cfg[(EXTIN+o)*WF +: WT];
      out_comb[o] = |(sel & track_in);
      if (!cfg_en)
        external_output[o] = cfg[(EXTIN+o)*WF + WT] ? out_q[o] : out_comb[o];
    end
  end

  assign contention = |dup;
  assign oe_all     = cfg_en ? '0 : seen;
  assign out_all    = drv & oe_all;

  assign single_oe  = oe_all[WS-1:0];
  assign double_oe  = oe_all[WS +: WD];
  assign global_oe  = oe_all[WS+WD +: WG];
  assign single_out = out_all[WS-1:0];
  assign double_out = out_all[WS +: WD];
  assign global_out = out_all[WS+WD +: WG];
  assign cfg_out    = cfg[0];

  // Loading config clears the pin registers and the conflict flag. This
  // means a reg-mode pin presents 0 until its first sample after the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg      <= '0;
      in_q     <= '0;
      out_q    <= '0;
      conflict <= 1'b0;
    end else if (cfg_en) begin
      cfg      <= {cfg_in, cfg[CW-1:1]};
      in_q     <= '0;
      out_q    <= '0;
      conflict <= 1'b0;
    end else begin
      in_q  <= external_input;
      out_q <= out_comb;
      if (contention) conflict <= 1'b1;
    end
  end

endmodule
